// File: rtl/boot_loader.sv
// Copies a length-prefixed, checksummed program image from the byte-wide image ROM
// into instruction RAM, verifies it, then releases the processor with run.
module boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_LEN    = 254
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_we,
    output logic                  run,
    output logic                  busy,
    output logic                  error,
    output logic [7:0]            loaded_len
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [8:0]            MAX_LEN_C = 9'(MAX_LEN);

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [7:0]              len_r;
    logic [7:0]              sum_r;
    logic [ADDR_WIDTH-1:0]   last_idx_s;

    // Running image checksum: modulo-256 byte sum.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        logic [7:0] res;
        res = acc + data;
        return res;
    endfunction

    // Index of the final payload byte for the current image.
    assign last_idx_s = ADDR_WIDTH'(len_r) - ADDR_ONE;

    // Load sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            idx_r      <= ADDR_ZERO;
            len_r      <= 8'd0;
            sum_r      <= 8'd0;
            rom_addr   <= ADDR_ZERO;
            ram_addr   <= ADDR_ZERO;
            ram_data   <= 8'd0;
            ram_we     <= 1'b0;
            run        <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            loaded_len <= 8'd0;
        end else begin
            case (state_r)
                IDLE, RUN, ERROR: begin
                    ram_we <= 1'b0;
                    if (start) begin
                        run      <= 1'b0;
                        error    <= 1'b0;
                        rom_addr <= ADDR_ZERO;
                        busy     <= 1'b1;
                        state_r  <= HDR;
                    end else begin
                        state_r  <= state_r;
                    end
                end
                HDR: begin
                    len_r      <= rom_data;
                    loaded_len <= rom_data;
                    sum_r      <= 8'd0;
                    idx_r      <= ADDR_ZERO;
                    rom_addr   <= ADDR_ONE;
                    if ({1'b0, rom_data} > MAX_LEN_C) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ERROR;
                    end else if (rom_data == 8'd0) begin
                        state_r <= CHECK;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    ram_we   <= 1'b1;
                    ram_addr <= idx_r;
                    ram_data <= rom_data;
                    sum_r    <= csum_add(sum_r, rom_data);
                    rom_addr <= rom_addr + ADDR_ONE;
                    idx_r    <= idx_r + ADDR_ONE;
                    if (idx_r == last_idx_s) begin
                        state_r <= CHECK;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                CHECK: begin
                    // rom_addr now points at the checksum byte following the payload.
                    ram_we <= 1'b0;
                    busy   <= 1'b0;
                    if (csum_add(sum_r, rom_data) == 8'd0) begin
                        run     <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        error   <= 1'b1;
                        state_r <= ERROR;
                    end
                end
                default: begin
                    ram_we  <= 1'b0;
                    run     <= 1'b0;
                    busy    <= 1'b0;
                    error   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed and randomized image loads for boot_loader, checked against a
// behavioural model of the image format and load timing.
module tb_boot_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       run;
    logic       busy;
    logic       error;
    logic [7:0] loaded_len;

    logic [7:0]  rom [0:255];
    logic [15:0] wq [$];
    int          checks;
    int          failures;

    boot_loader #(.ADDR_WIDTH(8), .MAX_LEN(254)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .run        (run),
        .busy       (busy),
        .error      (error),
        .loaded_len (loaded_len)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational image ROM.
    assign rom_data = rom[rom_addr];

    // Every cycle with ram_we high is one RAM write.
    always @(negedge clk) begin
        if (ram_we === 1'b1) wq.push_back({ram_addr, ram_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Random payload of n bytes with a correct or deliberately wrong checksum.
    task automatic setImage(input int n, input bit good);
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < 256; k++) rom[k] = 8'($urandom_range(0, 255));
        rom[0] = 8'(n);
        for (int k = 1; k <= n; k++) s = s + rom[k];
        rom[n + 1] = good ? (8'd0 - s) : (8'd0 - s + 8'($urandom_range(1, 255)));
    endtask

    // One load from start to outcome, compared against the image rules.
    task automatic doLoad(input bit holdStart);
        logic [7:0] hdr;
        logic [7:0] s;
        logic [3:0] expFlags;
        logic [3:0] endFlags;
        bit         over;
        bit         ok;
        int         n;
        int         outE;
        hdr  = rom[0];
        over = (hdr > 8'd254);
        n    = over ? 0 : int'(hdr);
        s    = 8'd0;
        for (int k = 1; k <= n; k++) s = s + rom[k];
        if (!over) s = s + rom[n + 1];
        ok       = !over && (s == 8'd0);
        outE     = over ? 1 : n + 2;
        endFlags = ok ? 4'b0100 : 4'b0010;
        wq.delete();
        start = 1'b1;
        @(posedge clk); #1;
        if (!holdStart) start = 1'b0;
        check("e0_flags", {busy, run, error, ram_we}, 4'b1000);
        check("e0_rom_addr", rom_addr, 0);
        for (int e = 1; e <= outE; e++) begin
            @(posedge clk); #1;
            expFlags = (e == outE) ? endFlags : {3'b100, (e >= 2)};
            check("flags", {busy, run, error, ram_we}, expFlags);
            check("rom_addr", rom_addr, (e <= n + 1) ? e : n + 1);
            if (e == 1) check("loaded_len", loaded_len, hdr);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_flags", {busy, run, error, ram_we}, endFlags);
        check("write_count", wq.size(), n);
        for (int k = 0; k < n && k < wq.size(); k++)
            check("write", wq[k], {k[7:0], rom[k + 1]});
        if (n > 0) check("ram_hold", {ram_addr, ram_data}, {8'(n - 1), rom[n]});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        for (int k = 0; k < 256; k++) rom[k] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rom_addr, ram_addr, ram_data, ram_we, run, busy, error, loaded_len}, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", {busy, run, error, ram_we}, 4'b0000);

        // Good 3-byte image, then bad checksum, then fixed.
        rom[0] = 8'h03; rom[1] = 8'h01; rom[2] = 8'h02; rom[3] = 8'h03; rom[4] = 8'hFA;
        doLoad(1'b0);
        rom[4] = 8'hFB;
        doLoad(1'b0);
        rom[4] = 8'hFA;
        doLoad(1'b0);

        // Empty images.
        rom[0] = 8'h00; rom[1] = 8'h00;
        doLoad(1'b0);
        rom[1] = 8'h01;
        doLoad(1'b0);

        // Oversize header.
        rom[0] = 8'hFF;
        doLoad(1'b0);

        // Reset mid-LOAD after the 10th write, then a full reload.
        setImage(20, 1'b1);
        wq.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {rom_addr, ram_addr, ram_data, ram_we, run, busy, error, loaded_len}, 0);
        check("writes_before_reset", wq.size(), 10);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", {busy, run, error, ram_we, rom_addr}, 0);
        check("no_writes_after_reset", wq.size(), 10);
        doLoad(1'b0);

        // Held start loads once; restart from RUN repeats the load.
        setImage(7, 1'b1);
        doLoad(1'b1);
        doLoad(1'b0);

        // Randomized images, including the largest legal length.
        for (int i = 0; i < 8; i++) begin
            setImage($urandom_range(1, 40), ($urandom_range(0, 2) != 0));
            doLoad($urandom_range(0, 1) == 1);
        end
        setImage(254, 1'b1);
        doLoad(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
